// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer.
// Define PARITY_EN for 8E1 frames (even parity bit between data and stop).
module uart_tx_fifo #(
  parameter int CLK_DIV = 5208,
  parameter int ADDR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_ready,
  input  logic [7:0]        tx_data,
  output logic              uart_tx,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf;
  state_t            r_state;
  logic [CW-1:0]     r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_tx;
`ifdef PARITY_EN
  logic              r_par;
`endif

  logic       w_bit_end;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic [7:0] w_head;
  logic       w_line;

  assign w_bit_end = (r_baud == CW'(CLK_DIV - 1));
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_head    = r_mem[r_rptr];
  // A full FIFO still takes a byte when the serializer frees a slot on the same edge.
  assign w_pop     = !w_empty &&
                     ((r_state == S_IDLE) ||
                      ((r_state == S_STOP) && w_bit_end));
  assign w_push    = tx_ready && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (tx_ready && !w_push) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_line = 1'b1;
    unique case (r_state)
      S_START:  w_line = 1'b0;
      S_DATA:   w_line = r_shift[0];
`ifdef PARITY_EN
      S_PARITY: w_line = r_par;
`endif
      default:  w_line = 1'b1;
    endcase
  end

  // Line register lags the state by one cycle, so the start bit begins
  // the edge after the pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_tx <= w_line;
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
`ifdef PARITY_EN
            r_par   <= ^w_head;
`endif
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
`ifdef PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_head;
`ifdef PARITY_EN
              r_par   <= ^w_head;
`endif
              r_bit   <= '0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_tx    = r_tx;
  assign busy       = (r_state != S_IDLE) | !w_empty;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: transaction-level model of FIFO
// acceptance, pop times and the expected serial line per cycle.
module tb_uart_tx_fifo;

  localparam int D     = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef PARITY_EN
  localparam int FR = 11 * D;
`else
  localparam int FR = 10 * D;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tx_ready = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          uart_tx;
  logic          busy;
  logic [AW:0]   fifo_count;
  logic          overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart_tx_fifo #(.CLK_DIV(D), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Model: accepted write edges, their bytes and their pop edges.
  int         acc_w[$];
  int         pop_p[$];
  logic [7:0] acc_b[$];
  bit         m_ovf;
  int         ovf_t;
  int         last_p;

  function automatic void model_reset();
    acc_w.delete();
    pop_p.delete();
    acc_b.delete();
    m_ovf  = 1'b0;
    ovf_t  = 0;
    last_p = -1000000;
  endfunction

  function automatic void model_write(int e, logic [7:0] d);
    int cnt = 0;
    bit popnow = 1'b0;
    int p;
    foreach (acc_w[i]) if (acc_w[i] < e) cnt++;
    foreach (pop_p[i]) begin
      if (pop_p[i] < e) cnt--;
      if (pop_p[i] == e) popnow = 1'b1;
    end
    if (cnt < DEPTH || popnow) begin
      p = (e + 1 > last_p + FR) ? e + 1 : last_p + FR;
      acc_w.push_back(e);
      acc_b.push_back(d);
      pop_p.push_back(p);
      last_p = p;
    end else if (!m_ovf) begin
      m_ovf = 1'b1;
      ovf_t = e;
    end
  endfunction

  function automatic logic exp_tx(int t);
    logic [7:0] b;
    int k;
    int bi;
    foreach (pop_p[j]) begin
      k = t - pop_p[j] - 1;
      if (k >= 0 && k < FR) begin
        b  = acc_b[j];
        bi = k / D;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
`ifdef PARITY_EN
        if (bi == 9) return ^b;
`endif
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [AW:0] exp_cnt(int t);
    int c = 0;
    foreach (acc_w[i]) if (acc_w[i] <= t) c++;
    foreach (pop_p[i]) if (pop_p[i] <= t) c--;
    return (AW+1)'(c);
  endfunction

  function automatic logic exp_busy(int t);
    if (exp_cnt(t) != 0) return 1'b1;
    foreach (pop_p[i]) if (pop_p[i] <= t && t < pop_p[i] + FR) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_ovf(int t);
    return m_ovf && (ovf_t <= t);
  endfunction

  task automatic do_reset();
    tx_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic clk_step(input bit rdy, input logic [7:0] d);
    tx_ready = rdy;
    tx_data  = d;
    @(posedge clk);
    #1;
    if (rdy) model_write(cyc, d);
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks += 4;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset tx got %b want 1", uart_tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    if (fifo_count !== '0) begin errors++; $display("FAIL reset count got %0d want 0", fifo_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset ovf got %b want 0", overflow); end
  endtask

  task automatic test_single();
    int w = -1;
    int low = -1;
    do_reset();
    for (int i = 0; i < FR + 12; i++) begin
      clk_step(i == 0, 8'hA5);
      if (i == 0) w = cyc;
      if (low < 0 && uart_tx === 1'b0) low = cyc;
      checks += 4;
      if (uart_tx !== exp_tx(cyc)) begin errors++; $display("FAIL single tx @%0d got %b want %b", cyc, uart_tx, exp_tx(cyc)); end
      if (fifo_count !== exp_cnt(cyc)) begin errors++; $display("FAIL single cnt @%0d got %0d want %0d", cyc, fifo_count, exp_cnt(cyc)); end
      if (busy !== exp_busy(cyc)) begin errors++; $display("FAIL single busy @%0d got %b want %b", cyc, busy, exp_busy(cyc)); end
      if (overflow !== exp_ovf(cyc)) begin errors++; $display("FAIL single ovf @%0d got %b want %b", cyc, overflow, exp_ovf(cyc)); end
    end
    checks++;
    if (low !== w + 2) begin errors++; $display("FAIL single start_edge got %0d want %0d", low, w + 2); end
  endtask

  task automatic test_back_to_back();
    logic [AW:0] peak = '0;
    do_reset();
    for (int i = 0; i < 4 * FR + 12; i++) begin
      clk_step(i < 4, 8'(i + 1));
      if (fifo_count > peak) peak = fifo_count;
      checks += 4;
      if (uart_tx !== exp_tx(cyc)) begin errors++; $display("FAIL b2b tx @%0d got %b want %b", cyc, uart_tx, exp_tx(cyc)); end
      if (fifo_count !== exp_cnt(cyc)) begin errors++; $display("FAIL b2b cnt @%0d got %0d want %0d", cyc, fifo_count, exp_cnt(cyc)); end
      if (busy !== exp_busy(cyc)) begin errors++; $display("FAIL b2b busy @%0d got %b want %b", cyc, busy, exp_busy(cyc)); end
      if (overflow !== exp_ovf(cyc)) begin errors++; $display("FAIL b2b ovf @%0d got %b want %b", cyc, overflow, exp_ovf(cyc)); end
    end
    checks += 2;
    if (peak !== 3) begin errors++; $display("FAIL b2b peak got %0d want 3", peak); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL b2b overflow got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5 * FR + 12; i++) begin
      clk_step(i < 6, 8'(8'h10 + i));
      checks += 4;
      if (uart_tx !== exp_tx(cyc)) begin errors++; $display("FAIL ovfl tx @%0d got %b want %b", cyc, uart_tx, exp_tx(cyc)); end
      if (fifo_count !== exp_cnt(cyc)) begin errors++; $display("FAIL ovfl cnt @%0d got %0d want %0d", cyc, fifo_count, exp_cnt(cyc)); end
      if (busy !== exp_busy(cyc)) begin errors++; $display("FAIL ovfl busy @%0d got %b want %b", cyc, busy, exp_busy(cyc)); end
      if (overflow !== exp_ovf(cyc)) begin errors++; $display("FAIL ovfl ovf @%0d got %b want %b", cyc, overflow, exp_ovf(cyc)); end
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovfl sticky got %b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    int target = -1;
    bit rdy;
    do_reset();
    for (int i = 0; i < 6 * FR + 12; i++) begin
      rdy = (i < 5) || (target > 0 && cyc + 1 == target);
      clk_step(rdy, 8'($urandom_range(0, 255)));
      if (i == 0) target = pop_p[0] + FR;
      if (cyc == target) begin
        checks += 2;
        if (fifo_count !== 4) begin errors++; $display("FAIL fullpop cnt got %0d want 4", fifo_count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop ovf got %b want 0", overflow); end
      end
      checks += 4;
      if (uart_tx !== exp_tx(cyc)) begin errors++; $display("FAIL fullpop tx @%0d got %b want %b", cyc, uart_tx, exp_tx(cyc)); end
      if (fifo_count !== exp_cnt(cyc)) begin errors++; $display("FAIL fullpop cnt @%0d got %0d want %0d", cyc, fifo_count, exp_cnt(cyc)); end
      if (busy !== exp_busy(cyc)) begin errors++; $display("FAIL fullpop busy @%0d got %b want %b", cyc, busy, exp_busy(cyc)); end
      if (overflow !== exp_ovf(cyc)) begin errors++; $display("FAIL fullpop ovf @%0d got %b want %b", cyc, overflow, exp_ovf(cyc)); end
    end
  endtask

  task automatic test_reset_mid();
    int stop_at;
    do_reset();
    clk_step(1'b1, 8'hFF);
    clk_step(1'b1, 8'hFF);
    stop_at = pop_p[0] + 1 + 3 * D + 2;
    for (int i = 0; i < 2 * FR && cyc < stop_at; i++) clk_step(1'b0, 8'h00);
    checks++;
    if (uart_tx !== 1'b0 && uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid pre tx got %b want 0/1", uart_tx); end
    #2 rst = 1'b0;
    #1;
    checks += 4;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid tx got %b want 1", uart_tx); end
    if (fifo_count !== '0) begin errors++; $display("FAIL rstmid cnt got %0d want 0", fifo_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy got %b want 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid ovf got %b want 0", overflow); end
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    for (int i = 0; i < FR + 12; i++) begin
      clk_step(i == 0, 8'h3C);
      checks += 4;
      if (uart_tx !== exp_tx(cyc)) begin errors++; $display("FAIL rstmid tx @%0d got %b want %b", cyc, uart_tx, exp_tx(cyc)); end
      if (fifo_count !== exp_cnt(cyc)) begin errors++; $display("FAIL rstmid cnt @%0d got %0d want %0d", cyc, fifo_count, exp_cnt(cyc)); end
      if (busy !== exp_busy(cyc)) begin errors++; $display("FAIL rstmid busy @%0d got %b want %b", cyc, busy, exp_busy(cyc)); end
      if (overflow !== exp_ovf(cyc)) begin errors++; $display("FAIL rstmid ovf @%0d got %b want %b", cyc, overflow, exp_ovf(cyc)); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 900 + 6 * FR; i++) begin
      clk_step((i < 900) && ($urandom_range(0, 39) == 0), 8'($urandom_range(0, 255)));
      checks += 4;
      if (uart_tx !== exp_tx(cyc)) begin errors++; $display("FAIL rand tx @%0d got %b want %b", cyc, uart_tx, exp_tx(cyc)); end
      if (fifo_count !== exp_cnt(cyc)) begin errors++; $display("FAIL rand cnt @%0d got %0d want %0d", cyc, fifo_count, exp_cnt(cyc)); end
      if (busy !== exp_busy(cyc)) begin errors++; $display("FAIL rand busy @%0d got %b want %b", cyc, busy, exp_busy(cyc)); end
      if (overflow !== exp_ovf(cyc)) begin errors++; $display("FAIL rand ovf @%0d got %b want %b", cyc, overflow, exp_ovf(cyc)); end
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic par0 = 1'bx;
    logic par1 = 1'bx;
    do_reset();
    for (int i = 0; i < 2 * FR + 20; i++) begin
      clk_step(i == 0 || i == FR + 5, (i == 0) ? 8'h07 : 8'h03);
      if (pop_p.size() > 0 && cyc == pop_p[0] + 1 + 9 * D + D / 2) par0 = uart_tx;
      if (pop_p.size() > 1 && cyc == pop_p[1] + 1 + 9 * D + D / 2) par1 = uart_tx;
      checks += 2;
      if (uart_tx !== exp_tx(cyc)) begin errors++; $display("FAIL parity tx @%0d got %b want %b", cyc, uart_tx, exp_tx(cyc)); end
      if (busy !== exp_busy(cyc)) begin errors++; $display("FAIL parity busy @%0d got %b want %b", cyc, busy, exp_busy(cyc)); end
    end
    checks += 2;
    if (par0 !== 1'b1) begin errors++; $display("FAIL parity 07 got %b want 1", par0); end
    if (par1 !== 1'b0) begin errors++; $display("FAIL parity 03 got %b want 0", par1); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
